// File: rtl/heap_move_long_if.sv
// Handshake and heap-memory bus between the instruction FSM, the moveLong
// sequencer and heapMemory.
interface heap_move_long_if #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 12,
  parameter int LEN_WIDTH  = 5
);
  logic                  start;
  logic [DATA_WIDTH-1:0] srcArray;
  logic [LEN_WIDTH-1:0]  srcOffset;
  logic [DATA_WIDTH-1:0] tgtArray;
  logic [LEN_WIDTH-1:0]  tgtOffset;
  logic [LEN_WIDTH-1:0]  length;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic                  sizeValid;
  logic [DATA_WIDTH-1:0] sizeArray;
  logic [LEN_WIDTH-1:0]  sizeValue;
  logic                  memWrite;
  logic [ADDR_WIDTH-1:0] memAddress;
  logic [DATA_WIDTH-1:0] memIn;
  logic [DATA_WIDTH-1:0] memOut;

  // Requester side: instruction FSM plus heapMemory read data
  modport master (
    output start, srcArray, srcOffset, tgtArray, tgtOffset, length, memOut,
    input  busy, done, error, sizeValid, sizeArray, sizeValue,
           memWrite, memAddress, memIn
  );

  // Sequencer side
  modport slave (
    input  start, srcArray, srcOffset, tgtArray, tgtOffset, length, memOut,
    output busy, done, error, sizeValid, sizeArray, sizeValue,
           memWrite, memAddress, memIn
  );
endinterface

// File: rtl/heap_move_long.sv
// moveLong sequencer: copies a run of heap words one at a time through the
// single-port heapMemory (read cycle, then write cycle per word). Copies
// within one array run backward when the target lies above the source, so
// overlapping moves behave like memmove.
module heap_move_long #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 12,
  parameter int NAREA      = 16,
  parameter int LEN_WIDTH  = 5
) (
  input logic            clock,
  input logic            reset,
  heap_move_long_if.slave bus
);

  localparam logic [LEN_WIDTH:0]    AREA_LIM = (LEN_WIDTH+1)'(NAREA);
  localparam logic [ADDR_WIDTH-1:0] AREA_SZ  = ADDR_WIDTH'(NAREA);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] src_arr_q, tgt_arr_q;
  logic [LEN_WIDTH-1:0]  src_off_q, tgt_off_q, len_q, idx_q;
  logic                  err_q, bwd_q;

  logic [LEN_WIDTH:0]    src_end, tgt_end;
  logic                  bound_err, accept, last;
  logic [LEN_WIDTH-1:0]  word_k;
  logic [ADDR_WIDTH-1:0] src_addr, tgt_addr;

  // Bounds are checked on the live request so the IDLE decision needs no extra cycle
  assign src_end   = {1'b0, bus.srcOffset} + {1'b0, bus.length};
  assign tgt_end   = {1'b0, bus.tgtOffset} + {1'b0, bus.length};
  assign bound_err = (src_end > AREA_LIM) || (tgt_end > AREA_LIM);
  assign accept    = (state_q == IDLE) && bus.start;
  assign last      = (idx_q == len_q - LEN_WIDTH'(1));
  assign word_k    = bwd_q ? (len_q - idx_q - LEN_WIDTH'(1)) : idx_q;
  assign src_addr  = ADDR_WIDTH'(src_arr_q) * AREA_SZ + ADDR_WIDTH'(src_off_q) + ADDR_WIDTH'(word_k);
  assign tgt_addr  = ADDR_WIDTH'(tgt_arr_q) * AREA_SZ + ADDR_WIDTH'(tgt_off_q) + ADDR_WIDTH'(word_k);

  // State register; reset aborts any move in progress at this edge
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Request latch and word index; only meaningful after an accepted start
  always_ff @(posedge clock) begin
    if (accept) begin
      src_arr_q <= bus.srcArray;
      src_off_q <= bus.srcOffset;
      tgt_arr_q <= bus.tgtArray;
      tgt_off_q <= bus.tgtOffset;
      len_q     <= bus.length;
      idx_q     <= '0;
      err_q     <= bound_err;
      bwd_q     <= (bus.srcArray == bus.tgtArray) && (bus.tgtOffset > bus.srcOffset);
    end else if (state_q == WRITE && !last) begin
      idx_q <= idx_q + LEN_WIDTH'(1);
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bound_err || bus.length == '0) state_d = DONE;
          else                               state_d = READ;
        end
      end
      READ:    state_d = WRITE;
      WRITE:   state_d = last ? DONE : READ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state and index; all zero in IDLE
  always_comb begin
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    bus.error      = 1'b0;
    bus.sizeValid  = 1'b0;
    bus.sizeArray  = '0;
    bus.sizeValue  = '0;
    bus.memWrite   = 1'b0;
    bus.memAddress = '0;
    bus.memIn      = '0;
    case (state_q)
      READ: begin
        bus.busy       = 1'b1;
        bus.memAddress = src_addr;
      end
      WRITE: begin
        bus.busy       = 1'b1;
        bus.memWrite   = 1'b1;
        bus.memAddress = tgt_addr;
        bus.memIn      = bus.memOut;
      end
      DONE: begin
        bus.busy  = 1'b1;
        bus.done  = 1'b1;
        bus.error = err_q;
        if (!err_q && len_q != '0) begin
          bus.sizeValid = 1'b1;
          bus.sizeArray = tgt_arr_q;
          bus.sizeValue = tgt_off_q + len_q;
        end
      end
      default: ;
    endcase
  end

endmodule
